// File: rtl/unary_dec_pipe.sv
// unary_dec_pipe: two-stage unary/thermometer admission check and length decoder with saturating reject counter
module unary_dec_pipe #(
  parameter int W = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [W-1:0]         i_x,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [$clog2(W)-1:0] o_len,
  output logic                 o_is_compliment,
  output logic                 o_err,
  input  logic                 i_err_clr,
  output logic [CNT_W-1:0]     o_err_cnt
);
  localparam int LW = $clog2(W);
  logic s1_valid, s1_nc, s1_cp, nc, cp, s2_en, inc;
  logic [W-1:0] s1_x, nx, pv;
  logic [LW-1:0] len;
  assign nx = ~i_x;
  // all-zero and all-ones satisfy the bit trick but are never admitted
  assign nc = (((i_x + W'(1)) & i_x) == '0) && (i_x != '0) && (i_x != '1);
  assign cp = P_ADMIT_COMPLIMENT_EN && (((nx + W'(1)) & nx) == '0) && (nx != '0) && (nx != '1);
  assign s2_en = !o_valid || i_ready;
  assign o_ready = !s1_valid || !o_valid || i_ready;
  assign inc = o_valid && i_ready && o_err;
  assign pv = s1_cp ? ~s1_x : s1_x;
  always_comb begin
    len = '0;
    for (int i = 0; i < W; i++) len = len + LW'(pv[i]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_x <= '0;
      s1_nc <= 1'b0;
      s1_cp <= 1'b0;
      o_valid <= 1'b0;
      o_len <= '0;
      o_is_compliment <= 1'b0;
      o_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        s1_x <= i_x;
        s1_nc <= nc;
        s1_cp <= cp;
      end
      if (s2_en) begin
        o_valid <= s1_valid;
        o_len <= (s1_nc || s1_cp) ? len : '0;
        o_is_compliment <= s1_cp;
        o_err <= !(s1_nc || s1_cp);
      end
      o_err_cnt <= i_err_clr ? CNT_W'(inc) : (inc && o_err_cnt != '1) ? o_err_cnt + CNT_W'(1) : o_err_cnt;
    end
  end
endmodule

// File: tb/tb_unary_dec_pipe.sv
// tb_unary_dec_pipe: scoreboard bench driving a compl-off/CNT_W=16 and a compl-on/CNT_W=2 instance in lockstep
module tb_unary_dec_pipe;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1, i_err_clr = 1'b0;
  logic [W-1:0] i_x = '0;
  logic ready_a, valid_a, comp_a, err_a, ready_b, valid_b, comp_b, err_b;
  logic [3:0] len_a, len_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;
  typedef struct {
    logic [3:0] la;
    logic ea;
    logic [3:0] lb;
    logic cb;
    logic eb;
    int cyc;
    bit lat;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, ready_mode = 0;
  logic [15:0] m_cnt_a = '0;
  logic [1:0] m_cnt_b = '0;
  logic hold_v = 1'b0;
  logic [3:0] hold_la, hold_lb;
  logic hold_ea, hold_eb, hold_cb;

  unary_dec_pipe #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b0), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(ready_a),
    .o_valid(valid_a), .i_ready(i_ready), .o_len(len_a), .o_is_compliment(comp_a),
    .o_err(err_a), .i_err_clr(i_err_clr), .o_err_cnt(cnt_a));
  unary_dec_pipe #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b1), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(ready_b),
    .o_valid(valid_b), .i_ready(i_ready), .o_len(len_b), .o_is_compliment(comp_b),
    .o_err(err_b), .i_err_clr(i_err_clr), .o_err_cnt(cnt_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    i_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : (($urandom % 2) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference: x is admitted as length k iff it equals k low ones (or, complemented, k low zeros)
  function automatic exp_t model(input logic [W-1:0] x, input bit lat);
    exp_t e;
    logic [W-1:0] t;
    e.la = 0; e.ea = 1; e.lb = 0; e.cb = 0; e.eb = 1; e.cyc = cyc; e.lat = lat;
    for (int k = 1; k < W; k++) begin
      t = '0;
      for (int j = 0; j < k; j++) t[j] = 1'b1;
      if (x == t) begin e.ea = 0; e.la = 4'(k); e.eb = 0; e.lb = 4'(k); end
      if (x == ~t) begin e.eb = 0; e.lb = 4'(k); e.cb = 1; end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_cnt_a = '0;
      m_cnt_b = '0;
      hold_v = 1'b0;
    end else begin
      chk("ready_ab", 32'(ready_b), 32'(ready_a));
      chk("valid_ab", 32'(valid_b), 32'(valid_a));
      chk("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      chk("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
      if (hold_v) begin
        chk("hold_valid", 32'(valid_a), 32'd1);
        chk("hold_payload_a", {27'd0, err_a, len_a}, {27'd0, hold_ea, hold_la});
        chk("hold_payload_b", {26'd0, comp_b, err_b, len_b}, {26'd0, hold_cb, hold_eb, hold_lb});
      end
      if (valid_a && i_ready) begin
        if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("len_a", 32'(len_a), 32'(e.la));
          chk("err_a", 32'(err_a), 32'(e.ea));
          chk("comp_a", 32'(comp_a), 32'd0);
          chk("len_b", 32'(len_b), 32'(e.lb));
          chk("err_b", 32'(err_b), 32'(e.eb));
          chk("comp_b", 32'(comp_b), 32'(e.cb));
          if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + 2));
          m_cnt_a = i_err_clr ? 16'(e.ea) : (e.ea && m_cnt_a != 16'hFFFF) ? m_cnt_a + 16'd1 : m_cnt_a;
          m_cnt_b = i_err_clr ? 2'(e.eb) : (e.eb && m_cnt_b != 2'd3) ? m_cnt_b + 2'd1 : m_cnt_b;
        end
      end else if (i_err_clr) begin
        m_cnt_a = '0;
        m_cnt_b = '0;
      end
      hold_v = valid_a && !i_ready;
      hold_la = len_a; hold_ea = err_a; hold_lb = len_b; hold_eb = err_b; hold_cb = comp_b;
    end
  end

  task automatic send(input logic [W-1:0] x, input bit lat);
    int n = 0;
    i_valid = 1'b1;
    i_x = x;
    @(negedge clk);
    while (!ready_a && n < 200) begin @(negedge clk); n++; end
    if (!ready_a) chk("send_timeout", 32'd0, 32'd1);
    else q.push_back(model(x, lat));
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    idle(2);
  endtask

  task automatic clear();
    i_err_clr = 1'b1;
    idle(1);
    i_err_clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] x;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_fields", {28'd0, len_a}, 32'd0);
    @(posedge clk); #1;
    send(16'h0001, 1); send(16'h00FF, 1); send(16'h7FFF, 1);
    drain();
    send(16'h0000, 0); send(16'hFFFF, 0); send(16'h0029, 0); send(16'hFF00, 0);
    drain();
    chk("cnt_a_four", 32'(cnt_a), 32'd4);
    send(16'hFF00, 1); send(16'h8000, 1); send(16'hFFFE, 1); send(16'h0029, 1);
    drain();
    clear();
    chk("cnt_cleared", {14'd0, cnt_b, cnt_a}, 32'd0);
    send(16'h0000, 0); send(16'hFFFF, 0); send(16'h0029, 0); send(16'h1234, 0);
    drain();
    chk("cnt_b_sat", 32'(cnt_b), 32'd3);
    ready_mode = 1;
    fork
      begin send(16'h0003, 0); send(16'hFFF0, 0); send(16'h0055, 0); send(16'h003F, 0); end
      begin
        repeat (3) @(posedge clk);
        #3 chk("bp_ready_low", 32'(ready_a), 32'd0);
        repeat (2) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain();
    ready_mode = 1;
    send(16'h0000, 0);
    idle(3);
    i_err_clr = 1'b1;
    ready_mode = 0;
    idle(1);
    i_err_clr = 1'b0;
    idle(1);
    chk("clr_inc_b", 32'(cnt_b), 32'd1);
    chk("clr_inc_a", 32'(cnt_a), 32'd1);
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom % 3)
        0: x = (W'(1) << $urandom_range(0, W)) - W'(1);
        1: x = ~((W'(1) << $urandom_range(0, W)) - W'(1));
        default: x = W'($urandom);
      endcase
      if ($urandom % 4 == 0) idle(1);
      if ($urandom % 40 == 0) clear();
      send(x, 0);
    end
    ready_mode = 0;
    drain();
    ready_mode = 1;
    send(16'h0000, 0); send(16'h0001, 0);
    rst = 1'b1;
    q.delete();
    idle(1);
    @(negedge clk);
    chk("midrst_valid", 32'(valid_a), 32'd0);
    chk("midrst_ready", 32'(ready_a), 32'd1);
    chk("midrst_cnt", {14'd0, cnt_b, cnt_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    idle(6);
    send(16'h000F, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
